block_scheduler: RTL and testbench
==================================

# block_scheduler

Sequences the falling-block lanes of the game. Owns a bank of `block` instances and drives their `block_ready`, `restart`, `Block_X_Center` and `Block_Y_Step` inputs. Counts collisions against a life budget and detects level completion from the blocks' `end_level` flags. Advances the level and raises fall speed. Sits between the top-level game FSM/keypad and the block bank; all outputs are registered on `frame_clk`.

## Interface
Parameters:
- `NUM_BLOCKS`, 4: number of block lanes driven (2..8).
- `SPAWN_GAP`, 60: frames between successive lane releases.
- `PAUSE_FRAMES`, 120: inter-level pause length in frames.
- `START_LIVES`, 3: lives loaded on game start (1..3).
- `INIT_STEP`, 1: `Block_Y_Step` at level 0.
- `MAX_STEP`, 8: saturation value of `Block_Y_Step`.

Ports:
- `frame_clk` in 1: the only clock; one edge per video frame.
- `Reset` in 1: synchronous, active-high; forces the reset state below.
- `restart` in 1: synchronous, active-high; same effect as `Reset`.
- `start` in 1: level-sensitive; leaves IDLE or GAME_OVER.
- `Collision` in NUM_BLOCKS: per-lane hit flag from collision logic.
- `end_level` in NUM_BLOCKS: per-lane "block off screen" flag from `block`.
- `block_ready` out NUM_BLOCKS: per-lane release to `block`.
- `block_restart` out 1: one-frame pulse to every `block.restart`.
- `Block_Y_Step` out 10: shared fall speed, pixels per frame.
- `Block_X_Center` out 10*NUM_BLOCKS: lane i occupies bits [10i+9:10i].
- `level` out 4: current level, saturates at 15.
- `lives` out 2: remaining lives.
- `playing` out 1: high in SPAWN and RUN.
- `game_over` out 1: high in GAME_OVER.

## Operation
- States: IDLE, SPAWN, RUN, LEVEL_DONE, GAME_OVER.
- Reset/restart values: state IDLE, `block_ready`=0, `block_restart`=0, `Block_Y_Step`=INIT_STEP, `level`=0, `lives`=START_LIVES, `playing`=0, `game_over`=0, lane i X=LANE_X[i].
- IDLE/GAME_OVER with `start`=1:
  - Reload lives=START_LIVES, level=0, step=INIT_STEP.
  - Pulse `block_restart`.
  - Go to SPAWN with gap counter=0 and spawn index=0.
- SPAWN, each frame:
  - If gap counter==0, set `block_ready[spawn_idx]` and increment spawn_idx.
  - Gap counter wraps at SPAWN_GAP-1.
  - When spawn_idx reaches NUM_BLOCKS, go to RUN.
  - Release bits stay set until leaving SPAWN/RUN.
- Collision event: a rising edge of the OR-reduction of `Collision`, registered against the previous frame.
  - Honoured only in SPAWN or RUN.
  - lives>1: decrement lives.
  - lives==1: lives=0, clear all `block_ready`, go to GAME_OVER.
- RUN with all `end_level` bits high and no collision event that frame:
  - Go to LEVEL_DONE.
  - Clear `block_ready`.
  - Pulse `block_restart`.
  - level=min(level+1,15); step=min(step+1,MAX_STEP).
  - Load the pause counter.
- LEVEL_DONE: after PAUSE_FRAMES frames, go to SPAWN (counters cleared as above).
- Lane X mapping: lane i X = LANE_X[(i+level) mod NUM_BLOCKS]. It updates the same edge as `level`.
- Arithmetic: step and level increment with saturation, never wrap. Lives never underflow below 0.

## Timing
- `block_ready[0]` is high on the first edge after entering SPAWN; lane k rises k*SPAWN_GAP frames later.
- SPAWN lasts (NUM_BLOCKS-1)*SPAWN_GAP+1 frames.
- `block_restart` is exactly one frame wide, asserted on the transition edge.
- Collision event and level-complete in the same frame: collision wins; level completion is re-evaluated next frame.
- A `Collision` held high for many frames costs one life only.
- `Reset`/`restart` mid-SPAWN, mid-RUN or mid-LEVEL_DONE: reset values apply on that edge, with no `block_restart` pulse.
- `start` is ignored in SPAWN, RUN and LEVEL_DONE.

## Structure
- Package `block_sched_pkg` contains:
  - `sched_state_t` enum.
  - `LANE_X` constant array: 80, 240, 400, 560, 120, 280, 440, 600.
  - Width localparams for level (4) and lives (2).
- One sub-module: `frame_counter`, a loadable down-counter with `done` output. Instantiated twice: spawn gap and level pause.

## Test plan
- Reset, then `start` 1 frame: `block_restart` pulses once; `block_ready` goes 0001, 0011, 0111, 1111 at frames 1, 61, 121, 181; `playing`=1.
- RUN with `end_level`=1111: next edge `block_ready`=0, `level`=1, `Block_Y_Step`=2, lane0 X=240; SPAWN re-entered 120 frames later.
- `Collision[2]` held high 10 frames at lives=3: lives=2 exactly once.
- Three separate collision pulses: lives 2, 1, then GAME_OVER with `game_over`=1, `block_ready`=0; `start` then restores lives=3, level=0.
- Collision and `end_level`=1111 in the same frame at lives=2: lives=1 and state stays RUN.
- Drive 20 level completions: `level` saturates at 15 and `Block_Y_Step` at 8. `restart` mid-pause returns to IDLE with all reset values.

Source files
------------

// File: rtl/block_sched_pkg.sv
// Shared types and constants for the block lane scheduler.
// Contents: scheduler state enum, counter/level/lives widths, the lane
// X-position table and a helper that rotates the table by the current level.
package block_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_RUN,
        S_LEVEL_DONE,
        S_GAME_OVER
    } sched_state_t;

    localparam int LEVEL_W = 4;
    localparam int LIVES_W = 2;
    localparam int CNT_W   = 16;
    localparam int X_W     = 10;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    // Entry 0 is the leftmost lane slot; the upper four are offset slots
    // used only when more than four lanes are instantiated.
    localparam logic [7:0][X_W-1:0] LANE_X = {
        10'd600, 10'd440, 10'd280, 10'd120,
        10'd560, 10'd400, 10'd240, 10'd80
    };

    // X centre of a lane: LANE_X[(lane + lvl) mod nb]. The modulo is done by
    // repeated subtraction; lane+lvl is at most 22, so 12 passes cover nb=2.
    function automatic logic [X_W-1:0] lane_x_at(input logic [4:0] lane,
                                                 input logic [LEVEL_W-1:0] lvl,
                                                 input logic [4:0] nb);
        logic [4:0] idx;
        idx = lane + 5'(lvl);
        for (int k = 0; k < 12; k++) begin
            if (idx >= nb) idx = idx - nb;
        end
        return LANE_X[idx[2:0]];
    endfunction

endpackage

// File: rtl/block_scheduler_frame_counter.sv
// frame_counter: loadable down-counter clocked once per frame.
// Ports:
//   clk      - frame clock
//   rst      - synchronous active-high clear (count to zero)
//   load     - load load_val this edge (has priority over en)
//   load_val - value to load
//   en       - decrement this edge; holds at zero
//   done     - count is zero
module frame_counter
    import block_sched_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/block_scheduler.sv
// block_scheduler: releases falling-block lanes, tracks lives and levels,
// raises fall speed per level. All outputs registered on frame_clk.
// Ports:
//   frame_clk      - frame clock (one edge per video frame)
//   Reset, restart - synchronous active-high reset (identical effect)
//   start          - leave IDLE / GAME_OVER
//   Collision      - per-lane hit flags
//   end_level      - per-lane "block off screen" flags
//   block_ready    - per-lane release
//   block_restart  - one-frame restart pulse to every block
//   Block_Y_Step   - shared fall speed
//   Block_X_Center - lane i X at bits [10i+9:10i]
//   level, lives   - current level and remaining lives
//   playing        - high in SPAWN/RUN
//   game_over      - high in GAME_OVER
//
// state        | meaning
// -------------+------------------------------------------------
// S_IDLE       | after reset, waiting for start
// S_SPAWN      | releasing lanes one per SPAWN_GAP frames
// S_RUN        | all lanes released, waiting for level end
// S_LEVEL_DONE | inter-level pause, PAUSE_FRAMES frames
// S_GAME_OVER  | lives exhausted, waiting for start
module block_scheduler
    import block_sched_pkg::*;
#(
    parameter int NUM_BLOCKS   = 4,
    parameter int SPAWN_GAP    = 60,
    parameter int PAUSE_FRAMES = 120,
    parameter int START_LIVES  = 3,
    parameter int INIT_STEP    = 1,
    parameter int MAX_STEP     = 8
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      restart,
    input  logic                      start,
    input  logic [NUM_BLOCKS-1:0]     Collision,
    input  logic [NUM_BLOCKS-1:0]     end_level,
    output logic [NUM_BLOCKS-1:0]     block_ready,
    output logic                      block_restart,
    output logic [9:0]                Block_Y_Step,
    output logic [10*NUM_BLOCKS-1:0]  Block_X_Center,
    output logic [LEVEL_W-1:0]        level,
    output logic [LIVES_W-1:0]        lives,
    output logic                      playing,
    output logic                      game_over
);

    sched_state_t state_q, state_d;
    logic [NUM_BLOCKS-1:0]    ready_q, ready_d;
    logic                     restart_q, restart_d;
    logic [9:0]               step_q, step_d;
    logic [LEVEL_W-1:0]       level_q, level_d;
    logic [LIVES_W-1:0]       lives_q, lives_d;
    logic [3:0]               spawn_idx_q, spawn_idx_d;
    logic                     coll_prev_q;
    logic [10*NUM_BLOCKS-1:0] x_q, x_d;
    logic                     playing_q, game_over_q;

    logic rst;
    logic coll_any, coll_event;
    logic gap_load, gap_en, gap_done;
    logic pause_load, pause_en, pause_done;
    logic [CNT_W-1:0] gap_val;

    assign rst        = Reset | restart;
    assign coll_any   = |Collision;
    assign coll_event = coll_any & ~coll_prev_q;

    frame_counter #(.WIDTH(CNT_W)) u_gap_cnt (
        .clk      (frame_clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_val),
        .en       (gap_en),
        .done     (gap_done)
    );

    frame_counter #(.WIDTH(CNT_W)) u_pause_cnt (
        .clk      (frame_clk),
        .rst      (rst),
        .load     (pause_load),
        .load_val (CNT_W'(PAUSE_FRAMES - 1)),
        .en       (pause_en),
        .done     (pause_done)
    );

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        restart_d   = 1'b0;
        step_d      = step_q;
        level_d     = level_q;
        lives_d     = lives_q;
        spawn_idx_d = spawn_idx_q;
        gap_load    = 1'b0;
        gap_val     = '0;
        gap_en      = 1'b0;
        pause_load  = 1'b0;
        pause_en    = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    lives_d     = LIVES_W'(START_LIVES);
                    level_d     = '0;
                    step_d      = 10'(INIT_STEP);
                    restart_d   = 1'b1;
                    ready_d     = '0;
                    spawn_idx_d = '0;
                    gap_load    = 1'b1;
                    state_d     = S_SPAWN;
                end
            end

            S_SPAWN, S_RUN: begin
                if (coll_event && (lives_q <= LIVES_W'(1))) begin
                    lives_d = '0;
                    ready_d = '0;
                    state_d = S_GAME_OVER;
                end else begin
                    if (coll_event) begin
                        lives_d = lives_q - 1'b1;
                    end
                    if (state_q == S_SPAWN) begin
                        if (gap_done) begin
                            for (int i = 0; i < NUM_BLOCKS; i++) begin
                                if (spawn_idx_q == 4'(i)) ready_d[i] = 1'b1;
                            end
                            spawn_idx_d = spawn_idx_q + 4'd1;
                            gap_load    = 1'b1;
                            gap_val     = CNT_W'(SPAWN_GAP - 1);
                            if (spawn_idx_d == 4'(NUM_BLOCKS)) begin
                                state_d = S_RUN;
                            end
                        end else begin
                            gap_en = 1'b1;
                        end
                    end else if (!coll_event && (&end_level)) begin
                        // A collision in the same frame defers level completion.
                        ready_d    = '0;
                        restart_d  = 1'b1;
                        level_d    = (level_q == LEVEL_MAX) ? level_q : level_q + 1'b1;
                        step_d     = (step_q < 10'(MAX_STEP)) ? step_q + 10'd1 : step_q;
                        pause_load = 1'b1;
                        state_d    = S_LEVEL_DONE;
                    end
                end
            end

            S_LEVEL_DONE: begin
                if (pause_done) begin
                    spawn_idx_d = '0;
                    gap_load    = 1'b1;
                    state_d     = S_SPAWN;
                end else begin
                    pause_en = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Lane positions follow the level that will be registered this edge.
    always_comb begin
        x_d = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            x_d[10*i +: 10] = lane_x_at(5'(i), level_d, 5'(NUM_BLOCKS));
        end
    end

    always_ff @(posedge frame_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= '0;
            restart_q   <= 1'b0;
            step_q      <= 10'(INIT_STEP);
            level_q     <= '0;
            lives_q     <= LIVES_W'(START_LIVES);
            spawn_idx_q <= '0;
            coll_prev_q <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                x_q[10*i +: 10] <= lane_x_at(5'(i), '0, 5'(NUM_BLOCKS));
            end
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            restart_q   <= restart_d;
            step_q      <= step_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            spawn_idx_q <= spawn_idx_d;
            coll_prev_q <= coll_any;
            playing_q   <= (state_d == S_SPAWN) || (state_d == S_RUN);
            game_over_q <= (state_d == S_GAME_OVER);
            x_q         <= x_d;
        end
    end

    assign block_ready    = ready_q;
    assign block_restart  = restart_q;
    assign Block_Y_Step   = step_q;
    assign Block_X_Center = x_q;
    assign level          = level_q;
    assign lives          = lives_q;
    assign playing        = playing_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_block_scheduler.sv
module tb_block_scheduler;

    logic        frame_clk;
    logic        Reset, restart, start;
    logic [3:0]  Collision, end_level;
    logic [3:0]  block_ready;
    logic        block_restart;
    logic [9:0]  Block_Y_Step;
    logic [39:0] Block_X_Center;
    logic [3:0]  level;
    logic [1:0]  lives;
    logic        playing, game_over;

    int checks   = 0;
    int failures = 0;

    localparam logic [39:0] X_L0 = {10'd560, 10'd400, 10'd240, 10'd80};
    localparam logic [39:0] X_L1 = {10'd80, 10'd560, 10'd400, 10'd240};

    block_scheduler dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .restart        (restart),
        .start          (start),
        .Collision      (Collision),
        .end_level      (end_level),
        .block_ready    (block_ready),
        .block_restart  (block_restart),
        .Block_Y_Step   (Block_Y_Step),
        .Block_X_Center (Block_X_Center),
        .level          (level),
        .lives          (lives),
        .playing        (playing),
        .game_over      (game_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"},   64'(block_ready),    64'h0);
        chk({tag, "_brst"},    64'(block_restart),  64'h0);
        chk({tag, "_step"},    64'(Block_Y_Step),   64'd1);
        chk({tag, "_level"},   64'(level),          64'd0);
        chk({tag, "_lives"},   64'(lives),          64'd3);
        chk({tag, "_playing"}, 64'(playing),        64'd0);
        chk({tag, "_gover"},   64'(game_over),      64'd0);
        chk({tag, "_x"},       64'(Block_X_Center), 64'(X_L0));
    endtask

    initial begin
        Reset = 1'b1; restart = 1'b0; start = 1'b0;
        Collision = '0; end_level = '0;
        tick();
        Reset = 1'b0;
        chk_reset_values("rst");

        // start for one frame, then lane release schedule
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_brst",    64'(block_restart), 64'd1);
        chk("start_playing", 64'(playing),       64'd1);
        chk("start_ready",   64'(block_ready),   64'h0);
        tick();
        chk("f1_ready", 64'(block_ready),   64'h1);
        chk("f1_brst",  64'(block_restart), 64'd0);
        ticks(59);
        chk("f60_ready",  64'(block_ready), 64'h1);
        tick();
        chk("f61_ready",  64'(block_ready), 64'h3);
        ticks(60);
        chk("f121_ready", 64'(block_ready), 64'h7);
        ticks(59);
        chk("f180_ready", 64'(block_ready), 64'h7);
        tick();
        chk("f181_ready",   64'(block_ready), 64'hF);
        chk("f181_playing", 64'(playing),     64'd1);

        // held collision costs one life
        Collision = 4'b0100;
        tick();
        chk("hold_first", 64'(lives), 64'd2);
        ticks(9);
        Collision = '0;
        tick();
        chk("hold_end", 64'(lives), 64'd2);

        // collision and level end in the same frame: collision wins
        Collision = 4'b0001;
        end_level = 4'hF;
        tick();
        chk("both_lives",   64'(lives),       64'd1);
        chk("both_ready",   64'(block_ready), 64'hF);
        chk("both_level",   64'(level),       64'd0);
        chk("both_playing", 64'(playing),     64'd1);
        tick();
        Collision = '0;
        end_level = '0;
        chk("ld_ready", 64'(block_ready),    64'h0);
        chk("ld_level", 64'(level),          64'd1);
        chk("ld_step",  64'(Block_Y_Step),   64'd2);
        chk("ld_brst",  64'(block_restart),  64'd1);
        chk("ld_x",     64'(Block_X_Center), 64'(X_L1));
        chk("ld_lane0", 64'(Block_X_Center[9:0]), 64'd240);
        ticks(119);
        chk("pause119_playing", 64'(playing), 64'd0);
        tick();
        chk("pause120_playing", 64'(playing),     64'd1);
        chk("pause120_ready",   64'(block_ready), 64'h0);
        chk("pause120_brst",    64'(block_restart), 64'd0);
        tick();
        chk("respawn_ready", 64'(block_ready), 64'h1);

        // last life lost in SPAWN
        Collision = 4'b0001;
        tick();
        Collision = '0;
        chk("go1_gover", 64'(game_over),   64'd1);
        chk("go1_ready", 64'(block_ready), 64'h0);
        chk("go1_lives", 64'(lives),       64'd0);
        chk("go1_play",  64'(playing),     64'd0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_lives", 64'(lives),          64'd3);
        chk("rs_level", 64'(level),          64'd0);
        chk("rs_step",  64'(Block_Y_Step),   64'd1);
        chk("rs_brst",  64'(block_restart),  64'd1);
        chk("rs_gover", 64'(game_over),      64'd0);
        chk("rs_x",     64'(Block_X_Center), 64'(X_L0));
        ticks(181);
        chk("rs_run_ready", 64'(block_ready), 64'hF);

        // three separate pulses
        for (int p = 0; p < 3; p++) begin
            Collision = 4'b1000;
            tick();
            Collision = '0;
            chk("pulse_lives", 64'(lives), 64'(2 - p));
            ticks(2);
        end
        chk("go2_gover", 64'(game_over),   64'd1);
        chk("go2_ready", 64'(block_ready), 64'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs2_lives", 64'(lives), 64'd3);
        chk("rs2_level", 64'(level), 64'd0);
        ticks(181);

        // level / step saturation over 20 completions
        for (int k = 1; k <= 20; k++) begin
            end_level = 4'hF;
            tick();
            end_level = '0;
            chk("sat_level", 64'(level),        64'((k > 15) ? 15 : k));
            chk("sat_step",  64'(Block_Y_Step), 64'((k + 1 > 8) ? 8 : k + 1));
            chk("sat_ready", 64'(block_ready),  64'h0);
            if (k < 20) begin
                ticks(120 + 181);
            end
        end
        chk("sat_lane0", 64'(Block_X_Center[9:0]), 64'd560);

        // restart mid-pause
        ticks(50);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_reset_values("mid");
        tick();
        chk("idle_brst",  64'(block_restart), 64'd0);
        chk("idle_ready", 64'(block_ready),   64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
